// File: rtl/counter_slot_arbiter_if.sv
// Request/grant bundle between the requesters and the shared 3-bit counter sequencer.
// The master drives requests and terminal counts. The slave returns grant, count, done and busy.
interface counter_slot_arbiter_if #(
  parameter int NREQ = 4,
  parameter int CW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] term;
  logic [NREQ-1:0]    gnt;
  logic [CW-1:0]      count;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport master (output req, term, input gnt, count, done, busy);
  modport slave  (input req, term, output gnt, count, done, busy);
endinterface

// File: rtl/counter_slot_arbiter.sv
// Round-robin owner of a shared 3-bit counter. It grants one requester, counts 0..term,
// pulses done and then releases the counter for the next requester.
module counter_slot_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  counter_slot_arbiter_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, REL} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [CW-1:0]   r_term_q, w_term_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic            r_busy;
  logic            w_found;
  logic [IW-1:0]   w_win;
  int              w_idx;

  // The search starts at the largest offset so that the nearest requester after last is kept.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NREQ;
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_win   = IW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_count_nxt = r_count;
    w_term_nxt  = r_term_q;
    w_last_nxt  = r_last;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: begin
        w_count_nxt = '0;
        if (w_found) begin
          w_state_nxt        = RUN;
          w_gnt_nxt          = '0;
          w_gnt_nxt[w_win]   = 1'b1;
          w_term_nxt         = bus.term[int'(w_win)*CW +: CW];
          w_owner_nxt        = w_win;
        end
      end
      RUN: begin
        // An abort wins over a terminal match in the same cycle.
        if (!bus.req[r_owner]) begin
          w_state_nxt = REL;
          w_gnt_nxt   = '0;
          w_count_nxt = '0;
          w_last_nxt  = r_owner;
        end else if (r_count == r_term_q) begin
          w_state_nxt         = REL;
          w_done_nxt[r_owner] = 1'b1;
          w_gnt_nxt           = '0;
          w_count_nxt         = '0;
          w_last_nxt          = r_owner;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      REL:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_last  <= IW'(NREQ - 1);
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_last  <= w_last_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // The terminal value is only read while the owner is known, so it needs no reset.
  always_ff @(posedge clk) begin
    r_term_q <= w_term_nxt;
  end

  assign bus.gnt   = r_gnt;
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Directed bench for counter_slot_arbiter (NREQ=4, CW=3): grant order, run length, abort and reset.
module tb_counter_slot_arbiter;
  logic clk;
  logic rstn;
  int   n_err;
  int   n_chk;

  counter_slot_arbiter_if #(.NREQ(4), .CW(3)) bus ();

  counter_slot_arbiter #(.NREQ(4), .CW(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_err    = 0;
    n_chk    = 0;
    rstn     = 1'b0;
    bus.req  = '0;
    bus.term = '0;
    #1;
    chk("rst_gnt",   32'(bus.gnt),   0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_done",  32'(bus.done),  0);
    chk("rst_busy",  32'(bus.busy),  0);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("idle_busy", 32'(bus.busy), 0);

    // single requester 1, term=3
    bus.req  = 4'b0010;
    bus.term = 12'h018;
    step();
    chk("s_gnt",  32'(bus.gnt),   32'h2);
    chk("s_cnt0", 32'(bus.count), 0);
    chk("s_busy", 32'(bus.busy),  1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("s_cnt", 32'(bus.count), 32'(i));
      chk("s_gnt_run", 32'(bus.gnt), 32'h2);
    end
    step();
    chk("s_done",     32'(bus.done),  32'h2);
    chk("s_done_gnt", 32'(bus.gnt),   0);
    chk("s_done_cnt", 32'(bus.count), 0);
    chk("s_rel_busy", 32'(bus.busy),  1);
    bus.req = '0;
    step();
    chk("s_idle_busy", 32'(bus.busy), 0);
    chk("s_idle_done", 32'(bus.done), 0);

    // round robin from a fresh pointer, all term=1
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    bus.req  = 4'b1111;
    bus.term = 12'h249;
    step();
    for (int g = 0; g < 5; g++) begin
      chk("rr_gnt",  32'(bus.gnt),   32'(1) << (g % 4));
      chk("rr_cnt0", 32'(bus.count), 0);
      step();
      chk("rr_cnt1", 32'(bus.count), 1);
      step();
      chk("rr_done", 32'(bus.done),  32'(1) << (g % 4));
      chk("rr_gnt0", 32'(bus.gnt),   0);
      step();
      chk("rr_idle", 32'(bus.busy),  0);
      if (g == 4) bus.req = '0;
      step();
    end
    chk("rr_quiet", 32'(bus.busy), 0);

    // term=7 on requester 1
    bus.req  = 4'b0010;
    bus.term = 12'h038;
    step();
    chk("t7_gnt",  32'(bus.gnt),   32'h2);
    chk("t7_cnt0", 32'(bus.count), 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("t7_cnt", 32'(bus.count), 32'(i));
      chk("t7_gnt_run", 32'(bus.gnt), 32'h2);
    end
    step();
    chk("t7_done", 32'(bus.done),  32'h2);
    chk("t7_cnt",  32'(bus.count), 0);
    bus.req = '0;
    step();
    chk("t7_idle", 32'(bus.busy), 0);

    // term=0 on requester 2
    bus.req  = 4'b0100;
    bus.term = 12'h000;
    step();
    chk("t0_gnt", 32'(bus.gnt),   32'h4);
    chk("t0_cnt", 32'(bus.count), 0);
    step();
    chk("t0_done", 32'(bus.done), 32'h4);
    chk("t0_gnt0", 32'(bus.gnt),  0);
    bus.req = '0;
    step();
    chk("t0_idle", 32'(bus.busy), 0);

    // abort: owner 2 (term=5) drops req at count=2 while requester 0 waits
    bus.req  = 4'b0100;
    bus.term = 12'h140;
    step();
    chk("ab_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0101;
    step();
    step();
    chk("ab_cnt2", 32'(bus.count), 2);
    chk("ab_gnt_run", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0001;
    step();
    chk("ab_gnt0", 32'(bus.gnt),   0);
    chk("ab_cnt0", 32'(bus.count), 0);
    chk("ab_done", 32'(bus.done),  0);
    chk("ab_busy", 32'(bus.busy),  1);
    bus.term = 12'h002;
    step();
    chk("ab_idle", 32'(bus.busy), 0);
    step();
    chk("ab_next_gnt", 32'(bus.gnt), 32'h1);

    // term0 latched as 2, then changed to 6 mid-run
    bus.term = 12'h006;
    step();
    chk("tc_cnt1", 32'(bus.count), 1);
    step();
    chk("tc_cnt2", 32'(bus.count), 2);
    step();
    chk("tc_done", 32'(bus.done),  32'h1);
    chk("tc_gnt0", 32'(bus.gnt),   0);
    chk("tc_cnt0", 32'(bus.count), 0);
    bus.req = '0;
    step();
    chk("tc_idle", 32'(bus.busy), 0);

    // reset at count=4 with owner 3
    bus.req  = 4'b1000;
    bus.term = 12'hC00;
    step();
    chk("mr_gnt", 32'(bus.gnt), 32'h8);
    for (int i = 0; i < 4; i++) step();
    chk("mr_cnt4", 32'(bus.count), 4);
    rstn = 1'b0;
    #1;
    chk("mr_gnt0", 32'(bus.gnt),   0);
    chk("mr_cnt0", 32'(bus.count), 0);
    chk("mr_done", 32'(bus.done),  0);
    chk("mr_busy", 32'(bus.busy),  0);
    bus.req = 4'b1001;
    step();
    step();
    chk("mr_hold", 32'(bus.gnt), 0);
    rstn = 1'b1;
    step();
    chk("mr_first", 32'(bus.gnt),   32'h1);
    chk("mr_fcnt",  32'(bus.count), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
